// File: rtl/instr_decode.sv
// ID stage of the 5-stage MIPS pipeline: register file, control decode, sign extension,
// early beq resolution with MEM forwarding, and the ID/EX pipeline register.
module instr_decode #(
    parameter int RF_DEPTH          = 32,
    parameter bit RF_CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_id_pc_plus_4,
    input  logic [31:0] if_id_instr,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_result,
    input  logic        forward_a_d,
    input  logic        forward_b_d,
    input  logic [31:0] ex_mem_alu_out,
    input  logic        flush_ex,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic        jump,
    output logic [31:0] pc_jump,
    output logic [4:0]  rs_d,
    output logic [4:0]  rt_d,
    output logic        branch_d,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_to_reg,
    output logic        id_ex_mem_write,
    output logic        id_ex_alu_src,
    output logic        id_ex_reg_dst,
    output logic [2:0]  id_ex_alu_control,
    output logic [31:0] id_ex_rd1,
    output logic [31:0] id_ex_rd2,
    output logic [4:0]  id_ex_rs,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_rd,
    output logic [31:0] id_ex_sign_imm
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] sign_imm;
    } id_ex_t;

    logic [31:0] rf_q [RF_DEPTH];
    logic [31:0] rf_d [RF_DEPTH];
    id_ex_t      id_ex_q;
    id_ex_t      id_ex_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd_field;
    logic [31:0] sign_imm;
    logic        wb_we;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic        jump_c;
    logic [2:0]  alu_control;

    assign opcode   = if_id_instr[31:26];
    assign funct    = if_id_instr[5:0];
    assign rs_d     = if_id_instr[25:21];
    assign rt_d     = if_id_instr[20:16];
    assign rd_field = if_id_instr[15:11];
    assign sign_imm = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

    // r0 writes are dropped here so r0 never needs special handling on the write side
    assign wb_we = wb_reg_write && (wb_write_reg != 5'd0);

    always_comb begin
        rf_d = rf_q;
        if (wb_we) begin
            rf_d[wb_write_reg] = wb_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && RF_CLEAR_ON_RESET) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Write-through bypass lets the ID read see a value WB is writing this same cycle
    assign rd1 = (rs_d == 5'd0) ? 32'd0 :
                 (wb_we && (wb_write_reg == rs_d)) ? wb_result : rf_q[rs_d];
    assign rd2 = (rt_d == 5'd0) ? 32'd0 :
                 (wb_we && (wb_write_reg == rt_d)) ? wb_result : rf_q[rt_d];

    always_comb begin
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        reg_dst     = 1'b0;
        branch      = 1'b0;
        jump_c      = 1'b0;
        alu_control = 3'b000;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                case (funct)
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default: begin
                        alu_control = 3'b000;
                        reg_write   = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                mem_to_reg  = 1'b1;
                alu_control = 3'b010;
            end
            OP_SW: begin
                mem_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = 3'b010;
            end
            OP_BEQ: begin
                branch      = 1'b1;
                alu_control = 3'b110;
            end
            OP_ADDI: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = 3'b010;
            end
            OP_J: begin
                jump_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign op_a      = forward_a_d ? ex_mem_alu_out : rd1;
    assign op_b      = forward_b_d ? ex_mem_alu_out : rd2;
    assign branch_d  = branch;
    assign pc_src    = branch && (op_a == op_b);
    assign pc_branch = if_id_pc_plus_4 + {sign_imm[29:0], 2'b00};
    assign jump      = jump_c;
    assign pc_jump   = {if_id_pc_plus_4[31:28], if_id_instr[25:0], 2'b00};

    always_comb begin
        id_ex_d = '0;
        if (!flush_ex) begin
            id_ex_d.reg_write   = reg_write;
            id_ex_d.mem_to_reg  = mem_to_reg;
            id_ex_d.mem_write   = mem_write;
            id_ex_d.alu_src     = alu_src;
            id_ex_d.reg_dst     = reg_dst;
            id_ex_d.alu_control = alu_control;
            id_ex_d.rd1         = rd1;
            id_ex_d.rd2         = rd2;
            id_ex_d.rs          = rs_d;
            id_ex_d.rt          = rt_d;
            id_ex_d.rd          = rd_field;
            id_ex_d.sign_imm    = sign_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign id_ex_reg_write   = id_ex_q.reg_write;
    assign id_ex_mem_to_reg  = id_ex_q.mem_to_reg;
    assign id_ex_mem_write   = id_ex_q.mem_write;
    assign id_ex_alu_src     = id_ex_q.alu_src;
    assign id_ex_reg_dst     = id_ex_q.reg_dst;
    assign id_ex_alu_control = id_ex_q.alu_control;
    assign id_ex_rd1         = id_ex_q.rd1;
    assign id_ex_rd2         = id_ex_q.rd2;
    assign id_ex_rs          = id_ex_q.rs;
    assign id_ex_rt          = id_ex_q.rt;
    assign id_ex_rd          = id_ex_q.rd;
    assign id_ex_sign_imm    = id_ex_q.sign_imm;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: expected ID/EX contents are queued when an
// instruction is presented and compared after the clock edge that registers it.
module tb_instr_decode;

    logic        clk;
    logic        reset;
    logic [31:0] if_id_pc_plus_4;
    logic [31:0] if_id_instr;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_result;
    logic        forward_a_d;
    logic        forward_b_d;
    logic [31:0] ex_mem_alu_out;
    logic        flush_ex;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        jump;
    logic [31:0] pc_jump;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic        branch_d;
    logic        id_ex_reg_write;
    logic        id_ex_mem_to_reg;
    logic        id_ex_mem_write;
    logic        id_ex_alu_src;
    logic        id_ex_reg_dst;
    logic [2:0]  id_ex_alu_control;
    logic [31:0] id_ex_rd1;
    logic [31:0] id_ex_rd2;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic [31:0] id_ex_sign_imm;

    int n_vec = 0;
    int n_err = 0;

    logic [118:0] sb_q[$];
    string        tag_q[$];

    // control byte: {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, alu_control[2:0]}
    localparam logic [7:0] C_NONE = 8'b00000_000;
    localparam logic [7:0] C_ADD  = 8'b10001_010;
    localparam logic [7:0] C_SUB  = 8'b10001_110;
    localparam logic [7:0] C_AND  = 8'b10001_000;
    localparam logic [7:0] C_OR   = 8'b10001_001;
    localparam logic [7:0] C_SLT  = 8'b10001_111;
    localparam logic [7:0] C_RBAD = 8'b00001_000;
    localparam logic [7:0] C_LW   = 8'b11010_010;
    localparam logic [7:0] C_SW   = 8'b00110_010;
    localparam logic [7:0] C_BEQ  = 8'b00000_110;
    localparam logic [7:0] C_ADDI = 8'b10010_010;

    instr_decode #(.RF_DEPTH(32), .RF_CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset),
        .if_id_pc_plus_4(if_id_pc_plus_4), .if_id_instr(if_id_instr),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_result(wb_result),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .ex_mem_alu_out(ex_mem_alu_out), .flush_ex(flush_ex),
        .pc_src(pc_src), .pc_branch(pc_branch), .jump(jump), .pc_jump(pc_jump),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_reg_dst(id_ex_reg_dst), .id_ex_alu_control(id_ex_alu_control),
        .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_sign_imm(id_ex_sign_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [118:0] mk(input logic [7:0] c, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [31:0] imm);
        return {c, r1, r2, rs, rt, rd, imm};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        wb_reg_write = we;
        wb_write_reg = r;
        wb_result    = d;
    endtask

    // Queue the expected ID/EX word, take one edge, then compare against the head
    task automatic cycle(input string tag, input logic [118:0] e);
        logic [118:0] want;
        string        t;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        t    = tag_q.pop_front();
        chk(t, {id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_write, id_ex_alu_src,
                id_ex_reg_dst, id_ex_alu_control, id_ex_rd1, id_ex_rd2,
                id_ex_rs, id_ex_rt, id_ex_rd, id_ex_sign_imm}, want);
    endtask

    initial begin
        reset = 1'b1;
        if_id_pc_plus_4 = 32'd0;
        if_id_instr     = 32'd0;
        forward_a_d     = 1'b0;
        forward_b_d     = 1'b0;
        ex_mem_alu_out  = 32'd0;
        flush_ex        = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        cycle("reset", mk(C_NONE, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        // illegal opcode while WB writes r5
        wb(1'b1, 5'd5, 32'h0000_1234);
        if_id_instr = 32'hFC00_0000;
        cycle("illegal_op", mk(C_NONE, 0, 0, 0, 0, 0, 0));

        wb(1'b0, 5'd0, 32'd0);
        if_id_instr = 32'h00A5_1820;
        #1;
        chk("add_fields", {rs_d, rt_d, branch_d, jump}, {5'd5, 5'd5, 1'b0, 1'b0});
        cycle("add_r5", mk(C_ADD, 32'h1234, 32'h1234, 5, 5, 3, 32'h1820));

        wb(1'b1, 5'd7, 32'hDEAD_BEEF);
        if_id_instr = 32'h00E5_4020;
        cycle("bypass_r7", mk(C_ADD, 32'hDEAD_BEEF, 32'h1234, 7, 5, 8, 32'h4020));

        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        if_id_instr = 32'h00E0_4822;
        cycle("sub_r0_wb", mk(C_SUB, 32'hDEAD_BEEF, 32'd0, 7, 0, 9, 32'h4822));

        wb(1'b1, 5'd1, 32'd5);
        if_id_instr = 32'h0000_5024;
        cycle("and_r0_read", mk(C_AND, 32'd0, 32'd0, 0, 0, 10, 32'h5024));

        wb(1'b1, 5'd2, 32'd5);
        if_id_instr = 32'h0021_5825;
        cycle("or_r1", mk(C_OR, 32'd5, 32'd5, 1, 1, 11, 32'h5825));

        wb(1'b0, 5'd0, 32'd0);
        if_id_pc_plus_4 = 32'h0000_0040;
        if_id_instr     = 32'h1022_FFFF;
        #1;
        chk("beq_eq_comb", {branch_d, pc_src, pc_branch}, {1'b1, 1'b1, 32'h0000_003C});
        cycle("beq_eq", mk(C_BEQ, 32'd5, 32'd5, 1, 2, 31, 32'hFFFF_FFFF));

        wb(1'b1, 5'd2, 32'd6);
        #1;
        chk("beq_ne_comb", {branch_d, pc_src}, {1'b1, 1'b0});
        cycle("beq_ne", mk(C_BEQ, 32'd5, 32'd6, 1, 2, 31, 32'hFFFF_FFFF));

        wb(1'b1, 5'd1, 32'd9);
        #1;
        chk("beq_9_6_comb", {pc_src}, {1'b0});
        cycle("beq_9_6", mk(C_BEQ, 32'd9, 32'd6, 1, 2, 31, 32'hFFFF_FFFF));

        wb(1'b1, 5'd2, 32'd5);
        forward_a_d    = 1'b1;
        ex_mem_alu_out = 32'd5;
        #1;
        chk("beq_fwd_a", {pc_src}, {1'b1});
        cycle("beq_fwd_a_reg", mk(C_BEQ, 32'd9, 32'd5, 1, 2, 31, 32'hFFFF_FFFF));

        wb(1'b0, 5'd0, 32'd0);
        forward_a_d     = 1'b0;
        forward_b_d     = 1'b1;
        ex_mem_alu_out  = 32'd9;
        if_id_pc_plus_4 = 32'h0000_0004;
        if_id_instr     = 32'h1022_FFFD;
        #1;
        chk("beq_fwd_b_wrap", {pc_src, pc_branch}, {1'b1, 32'hFFFF_FFF8});
        cycle("beq_neg_imm", mk(C_BEQ, 32'd9, 32'd5, 1, 2, 31, 32'hFFFF_FFFD));

        forward_b_d     = 1'b0;
        if_id_pc_plus_4 = 32'h0040_0004;
        if_id_instr     = 32'h0800_0010;
        #1;
        chk("jump_comb", {jump, pc_jump, pc_src, branch_d}, {1'b1, 32'h0000_0040, 1'b0, 1'b0});
        cycle("jump_reg", mk(C_NONE, 0, 0, 0, 0, 0, 32'h0000_0010));

        if_id_instr = 32'h8C23_0004;
        flush_ex    = 1'b1;
        cycle("lw_flushed", mk(C_NONE, 0, 0, 0, 0, 0, 0));

        flush_ex = 1'b0;
        cycle("lw", mk(C_LW, 32'd9, 32'd0, 1, 3, 0, 32'h4));

        if_id_instr = 32'hAC22_0008;
        cycle("sw", mk(C_SW, 32'd9, 32'd5, 1, 2, 0, 32'h8));

        if_id_instr = 32'h2024_FFFF;
        cycle("addi", mk(C_ADDI, 32'd9, 32'd0, 1, 4, 31, 32'hFFFF_FFFF));

        if_id_instr = 32'h0022_602A;
        cycle("slt", mk(C_SLT, 32'd9, 32'd5, 1, 2, 12, 32'h602A));

        if_id_instr = 32'h0022_6027;
        cycle("rtype_bad_funct", mk(C_RBAD, 32'd9, 32'd5, 1, 2, 12, 32'h6027));

        // reset mid-run, racing a WB write to r1; reset must win
        reset = 1'b1;
        flush_ex = 1'b0;
        wb(1'b1, 5'd1, 32'h77);
        if_id_instr = 32'h0022_602A;
        cycle("reset_mid", mk(C_NONE, 0, 0, 0, 0, 0, 0));

        reset = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        if_id_instr = 32'h0022_6020;
        cycle("rf_cleared", mk(C_ADD, 32'd0, 32'd0, 1, 2, 12, 32'h6020));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
